// File: rtl/rt_pkg.sv
// Shared types and 7-segment glyphs for the multi-player reaction timer.
package rt_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    GO   = 3'd2,
    DONE = 3'd3,
    FOUL = 3'd4
  } state_t;

  typedef logic [3:0] bcd_t;

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_code(input bcd_t d);
    logic [6:0] c;
    case (d)
      4'd0:    c = SEG_DIGIT[0];
      4'd1:    c = SEG_DIGIT[1];
      4'd2:    c = SEG_DIGIT[2];
      4'd3:    c = SEG_DIGIT[3];
      4'd4:    c = SEG_DIGIT[4];
      4'd5:    c = SEG_DIGIT[5];
      4'd6:    c = SEG_DIGIT[6];
      4'd7:    c = SEG_DIGIT[7];
      4'd8:    c = SEG_DIGIT[8];
      4'd9:    c = SEG_DIGIT[9];
      default: c = SEG_BLANK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner: one digit enabled at a time, units at index 0.
module seg7_scan
  import rt_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 10000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic                  dash,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg
);

  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int IW = $clog2(DIGITS);

  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx;
  bcd_t          digit;
  logic [6:0]    code;

  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) digit = bcd[4*i +: 4];
    end
    code = dash ? SEG_DASH : seg_code(digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      an       <= '1;
      seg      <= 8'hFF;
    end else begin
      an  <= ~(DIGITS'(1) << idx);
      seg <= {1'b1, code};
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
    end
  end

endmodule

// File: rtl/reaction_timer_multi.sv
// NCH-player reaction timer with random go-delay, false-start detection and BCD ms count.
// Optional best-time register enabled by `define REACT_BEST_TIME_EN.
module reaction_timer_multi
  import rt_pkg::*;
#(
  parameter int          NCH             = 2,
  parameter int          DIGITS          = 4,
  parameter int          TICK_DIV        = 100000,
  parameter int          SCAN_DIV        = 10000,
  parameter int          DELAY_MIN_MS    = 1000,
  parameter int          DELAY_RAND_BITS = 10,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic              sysclk,
  input  logic              BTNU,
  input  logic              start,
  input  logic [NCH-1:0]    btn,
  input  logic              show_best,
  output logic              LED,
  output logic [DIGITS-1:0] AN,
  output logic [7:0]        leds,
  output logic [NCH-1:0]    winner,
  output logic              false_start,
  output logic              busy
);

  localparam int              TW        = $clog2(TICK_DIV + 1);
  localparam int              CW        = 4 * DIGITS;
  localparam logic [CW-1:0]   ALL_NINES = {DIGITS{4'h9}};
  localparam logic [2:0]      ST_IDLE   = IDLE;
  localparam logic [2:0]      ST_WAIT   = WAIT;
  localparam logic [2:0]      ST_GO     = GO;
  localparam logic [2:0]      ST_DONE   = DONE;
  localparam logic [2:0]      ST_FOUL   = FOUL;

  logic [2:0]     state;
  logic [15:0]    lfsr;
  logic [2:0]     start_sync;
  logic [NCH-1:0] btn_s1, btn_s2, btn_s3;
  logic [NCH-1:0] btn_edge, btn_first;
  logic           start_edge, tick;
  logic [TW-1:0]  tick_cnt;
  logic [31:0]    delay_cnt;
  logic [CW-1:0]  count, count_inc, disp_bcd;
  logic           disp_dash;

  function automatic logic [31:0] rand_part(input logic [15:0] v);
    logic [31:0] mask;
    mask = (DELAY_RAND_BITS == 0) ? 32'd0 : ((32'd1 << DELAY_RAND_BITS) - 32'd1);
    return {16'd0, v} & mask;
  endfunction

  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Input synchronisers; an edge acts on the third clock after the pin moves
  always_ff @(posedge sysclk) begin
    if (BTNU) begin
      start_sync <= '0;
      btn_s1     <= '0;
      btn_s2     <= '0;
      btn_s3     <= '0;
      lfsr       <= LFSR_SEED;
    end else begin
      start_sync <= {start_sync[1:0], start};
      btn_s1     <= btn;
      btn_s2     <= btn_s1;
      btn_s3     <= btn_s2;
      lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign start_edge = start_sync[1] & ~start_sync[2];
  assign btn_edge   = btn_s2 & ~btn_s3;
  assign btn_first  = btn_edge & (~btn_edge + NCH'(1));
  assign tick       = (tick_cnt == TW'(TICK_DIV - 1));
  assign count_inc  = bcd_inc(count);

  always_ff @(posedge sysclk) begin
    if (BTNU) begin
      state     <= ST_IDLE;
      LED       <= 1'b0;
      winner    <= '0;
      count     <= '0;
      tick_cnt  <= '0;
      delay_cnt <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      case (state)
        ST_IDLE, ST_DONE, ST_FOUL: begin
          if (start_edge) begin
            state     <= ST_WAIT;
            delay_cnt <= 32'(DELAY_MIN_MS) + rand_part(lfsr);
            count     <= '0;
            winner    <= '0;
            tick_cnt  <= '0;
            LED       <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (|btn_edge) begin
            state  <= ST_FOUL;
            winner <= btn_edge;
          end else if (delay_cnt == 32'd0) begin
            state    <= ST_GO;
            LED      <= 1'b1;
            tick_cnt <= '0;
          end else if (tick) begin
            delay_cnt <= delay_cnt - 32'd1;
          end
        end
        ST_GO: begin
          // A press wins over a coincident tick, so the count freezes un-incremented
          if (|btn_edge) begin
            state  <= ST_DONE;
            LED    <= 1'b0;
            winner <= btn_first;
          end else if (tick) begin
            count <= count_inc;
            if (count_inc == ALL_NINES) begin
              state <= ST_DONE;
              LED   <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef REACT_BEST_TIME_EN
  logic [CW-1:0] best;

  // BCD digits compare correctly as plain unsigned vectors
  always_ff @(posedge sysclk) begin
    if (BTNU) begin
      best <= ALL_NINES;
    end else if (state == ST_GO && (|btn_edge) && count < best) begin
      best <= count;
    end
  end
`else
  logic unused_show_best;
  assign unused_show_best = show_best;
`endif

  always_comb begin
    disp_bcd  = count;
    disp_dash = (state == ST_FOUL);
`ifdef REACT_BEST_TIME_EN
    if (show_best && (state == ST_IDLE || state == ST_DONE || state == ST_FOUL)) begin
      disp_bcd  = best;
      disp_dash = 1'b0;
    end
`endif
  end

  assign false_start = (state == ST_FOUL);
  assign busy        = (state == ST_WAIT) || (state == ST_GO);

  seg7_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk  (sysclk),
    .rst  (BTNU),
    .bcd  (disp_bcd),
    .dash (disp_dash),
    .an   (AN),
    .seg  (leds)
  );

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Scoreboard bench for reaction_timer_multi: random rounds against a ms-count reference model.
module tb_reaction_timer_multi;

`ifdef REACT_BEST_TIME_EN
  localparam bit BEST_EN = 1'b1;
`else
  localparam bit BEST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, show_best;
  logic [1:0] btn;
  logic       led;
  logic [3:0] an;
  logic [7:0] leds;
  logic [1:0] winner;
  logic       fs, busy;

  logic       start2, show2;
  logic [1:0] btn2;
  logic       led2;
  logic [1:0] an2;
  logic [7:0] leds2;
  logic [1:0] winner2;
  logic       fs2, busy2;

  reaction_timer_multi #(
    .NCH(2), .DIGITS(4), .TICK_DIV(10), .SCAN_DIV(4), .DELAY_MIN_MS(5), .DELAY_RAND_BITS(0)
  ) u_dut (
    .sysclk(clk), .BTNU(rst), .start(start), .btn(btn), .show_best(show_best),
    .LED(led), .AN(an), .leds(leds), .winner(winner), .false_start(fs), .busy(busy)
  );

  reaction_timer_multi #(
    .NCH(2), .DIGITS(2), .TICK_DIV(10), .SCAN_DIV(4), .DELAY_MIN_MS(5), .DELAY_RAND_BITS(0)
  ) u_dut2 (
    .sysclk(clk), .BTNU(rst), .start(start2), .btn(btn2), .show_best(show2),
    .LED(led2), .AN(an2), .leds(leds2), .winner(winner2), .false_start(fs2), .busy(busy2)
  );

  typedef struct {
    logic [1:0] winner;
    logic       fs;
    int         disp;
    bit         dash;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         mon_done = 0;
  int         best_model = 9999;
  logic [7:0] seen1 [4];
  logic [7:0] seen2 [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] seg_of(input int d, input bit dash);
    logic [6:0] c;
    if (dash) c = 7'b0111111;
    else begin
      case (d)
        0: c = 7'b1000000;  1: c = 7'b1111001;  2: c = 7'b0100100;
        3: c = 7'b0110000;  4: c = 7'b0011001;  5: c = 7'b0010010;
        6: c = 7'b0000010;  7: c = 7'b1111000;  8: c = 7'b0000000;
        9: c = 7'b0010000;  default: c = 7'b1111111;
      endcase
    end
    return {1'b1, c};
  endfunction

  task automatic read_disp1();
    for (int i = 0; i < 4; i++) seen1[i] = 8'h00;
    repeat (48) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) seen1[i] = leds;
    end
  endtask

  task automatic read_disp2();
    for (int i = 0; i < 2; i++) seen2[i] = 8'h00;
    repeat (24) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (an2 == ~(2'b01 << i)) seen2[i] = leds2;
    end
  endtask

  task automatic check_disp1(input string tag, input int value, input bit dash);
    int p;
    read_disp1();
    p = 1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_digit%0d", tag, i), seen1[i], seg_of((value / p) % 10, dash));
      p = p * 10;
    end
  endtask

  // Monitor: every time a round ends (busy falls) pop and compare the expected result
  initial begin : monitor
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_busy && !busy) begin
        check("result_queued", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("winner", winner, e.winner);
          check("false_start", fs, e.fs);
          check("led_off", led, 0);
          check_disp1("result", e.disp, e.dash);
        end
        mon_done++;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_mon(input int target);
    int n;
    n = 0;
    while (mon_done < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("monitor_done", mon_done >= target, 1);
  endtask

  task automatic begin_round(output bit ok);
    int n;
    @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = busy;
    check("busy_rise", busy, 1);
  endtask

  task automatic press(input logic [1:0] v);
    btn = v;
    repeat (2) @(negedge clk);
    btn = 2'b00;
  endtask

  task automatic go_round(input int ticks, input logic [1:0] v, input bit show);
    bit   ok;
    int   n, tgt;
    exp_t e;
    show_best = show;
    begin_round(ok);
    if (ok) begin
      n = 0;
      while (!led && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("led_delay_in_window", (led && n >= 47 && n <= 53), 1);
      repeat (10 * ticks + 3) @(negedge clk);
      if (ticks < best_model) best_model = ticks;
      e.winner = v[0] ? 2'b01 : 2'b10;
      e.fs     = 1'b0;
      e.disp   = (BEST_EN && show) ? best_model : ticks;
      e.dash   = 1'b0;
      exp_q.push_back(e);
      tgt = mon_done + 1;
      press(v);
      wait_mon(tgt);
    end
  endtask

  task automatic foul_round(input int dly, input logic [1:0] v, input bit show);
    bit   ok;
    int   tgt;
    exp_t e;
    show_best = show;
    begin_round(ok);
    if (ok) begin
      repeat (dly) @(negedge clk);
      e.winner = v;
      e.fs     = 1'b1;
      e.disp   = (BEST_EN && show) ? best_model : 0;
      e.dash   = !(BEST_EN && show);
      exp_q.push_back(e);
      tgt = mon_done + 1;
      press(v);
      wait_mon(tgt);
    end
  endtask

  initial begin : stimulus
    bit   ok;
    int   n, tgt, kind;
    exp_t e;
    logic [1:0] v;
    rst = 1'b1; start = 1'b0; btn = 2'b00; show_best = 1'b0;
    start2 = 1'b0; btn2 = 2'b00; show2 = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_led", led, 0);
    check("rst_an", an, 4'hF);
    check("rst_leds", leds, 8'hFF);
    check("rst_winner", winner, 0);
    check("rst_busy", busy, 0);
    check("rst_false_start", fs, 0);
    rst = 1'b0;
    check_disp1("after_reset", 0, 1'b0);

    // Normal round, false start, tie
    go_round(37, 2'b10, 1'b0);
    foul_round(12, 2'b01, 1'b0);
    go_round(23, 2'b11, 1'b0);

    // Timeout on the two-digit instance
    @(negedge clk);
    start2 = 1'b1;
    repeat (2) @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (!busy2 && n < 20) begin @(negedge clk); n++; end
    check("timeout_busy_rise", busy2, 1);
    n = 0;
    while (busy2 && n < 1500) begin @(negedge clk); n++; end
    check("timeout_done", busy2, 0);
    check("timeout_winner", winner2, 0);
    check("timeout_false_start", fs2, 0);
    check("timeout_led", led2, 0);
    read_disp2();
    check("timeout_digit0", seen2[0], seg_of(9, 1'b0));
    check("timeout_digit1", seen2[1], seg_of(9, 1'b0));

    // Reset in the middle of GO at count 12
    begin_round(ok);
    n = 0;
    while (!led && n < 100) begin @(negedge clk); n++; end
    check("midgo_led_on", led, 1);
    repeat (125) @(negedge clk);
    e.winner = 2'b00; e.fs = 1'b0; e.disp = 0; e.dash = 1'b0;
    exp_q.push_back(e);
    tgt = mon_done + 1;
    rst = 1'b1;
    @(negedge clk);
    check("midgo_led", led, 0);
    check("midgo_busy", busy, 0);
    rst = 1'b0;
    best_model = 9999;
    wait_mon(tgt);
    press(2'b01);
    repeat (10) @(negedge clk);
    check("ignored_btn_winner", winner, 0);
    check("ignored_btn_busy", busy, 0);

    // Best-time sequence with the best display selected
    go_round(37, 2'b01, 1'b1);
    go_round(52, 2'b10, 1'b1);
    go_round(20, 2'b01, 1'b1);

    // Randomised rounds
    for (int r = 0; r < 8; r++) begin
      kind = $urandom_range(0, 2);
      v    = 2'($urandom_range(1, 3));
      if (kind == 0) foul_round($urandom_range(0, 40), v, 1'($urandom_range(0, 1)));
      else           go_round($urandom_range(1, 60), v, 1'($urandom_range(0, 1)));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
